// File: rtl/alu_seq_if.sv
// Handshake/data bundle for alu_seq: upstream operand request and downstream result/flags.
// WIDTH must match the WIDTH of the alu_seq instance it connects to.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Alu_inputA;
    logic [WIDTH-1:0] Alu_inputB;
    logic [3:0]       Alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Alu_result;
    logic             Zero;
    logic             Carry;
    logic             Overflow;
    logic             Negative;
    logic             Err;

    modport slave (
        input  in_valid, Alu_inputA, Alu_inputB, Alu_control, out_ready,
        output in_ready, out_valid, Alu_result, Zero, Carry, Overflow, Negative, Err
    );

    modport master (
        output in_valid, Alu_inputA, Alu_inputB, Alu_control, out_ready,
        input  in_ready, out_valid, Alu_result, Zero, Carry, Overflow, Negative, Err
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and iterative shifts.
// Optional iterative shift-add multiplier on opcode 1000 when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'h8;
`endif

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             neg_q;
    logic             err_q;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       ctl;
    logic [SHAMT_W-1:0] shamt;

    assign op_a  = bus.Alu_inputA;
    assign op_b  = bus.Alu_inputB;
    assign ctl   = bus.Alu_control;
    assign shamt = op_b[SHAMT_W-1:0];

    logic accept;
    logic start_shift;
    logic start_mul;
    logic start_busy;

    assign accept      = (state == S_IDLE) && bus.in_valid;
    assign start_shift = ((ctl == OP_SHL) || (ctl == OP_SHR)) && (shamt != '0);
`ifdef ALU_MUL_EN
    assign start_mul   = (ctl == OP_MUL);
`else
    assign start_mul   = 1'b0;
`endif
    assign start_busy  = start_shift || start_mul;

    // Single-cycle datapath: evaluated directly on the incoming operands.
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] res1;
    logic             carry1;
    logic             ovf1;
    logic             err1;

    assign add_w = {1'b0, op_a} + {1'b0, op_b};
    assign sub_w = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        res1   = '0;
        carry1 = 1'b0;
        ovf1   = 1'b0;
        err1   = 1'b0;
        case (ctl)
            OP_ADD: begin
                res1   = add_w[WIDTH-1:0];
                carry1 = add_w[WIDTH];
                ovf1   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (add_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                res1   = sub_w[WIDTH-1:0];
                carry1 = sub_w[WIDTH];
                ovf1   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                         (sub_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: res1 = op_a & op_b;
            OP_OR:  res1 = op_a | op_b;
            OP_XOR: res1 = op_a ^ op_b;
            OP_SLT: res1 = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SHL: res1 = op_a;
            OP_SHR: res1 = op_a;
`ifdef ALU_MUL_EN
            OP_MUL: res1 = '0;
`endif
            default: err1 = 1'b1;
        endcase
    end

    // One iteration step; MUL reuses a_q as the right-shifting multiplier.
    logic [WIDTH-1:0] a_step;
    assign a_step = (op_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);

    logic [WIDTH-1:0] fin_res;
    logic             fin_carry;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = a_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (accept && start_mul) begin
            mcand_q <= {{WIDTH{1'b0}}, op_a};
            acc_q   <= '0;
        end else if (state == S_BUSY) begin
            mcand_q <= mcand_q << 1;
            acc_q   <= acc_next;
        end
    end
`endif

    always_comb begin
        fin_res   = a_step;
        fin_carry = 1'b0;
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
            fin_res   = acc_next[WIDTH-1:0];
            fin_carry = |acc_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            cnt     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= ctl;
                        if (start_busy) begin
                            a_q   <= start_mul ? op_b : op_a;
                            cnt   <= start_mul ? CNT_W'(WIDTH) : CNT_W'(shamt);
                            state <= S_BUSY;
                        end else begin
                            res_q   <= res1;
                            zero_q  <= (res1 == '0);
                            carry_q <= carry1;
                            ovf_q   <= ovf1;
                            neg_q   <= res1[WIDTH-1];
                            err_q   <= err1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        res_q   <= fin_res;
                        zero_q  <= (fin_res == '0);
                        carry_q <= fin_carry;
                        ovf_q   <= 1'b0;
                        neg_q   <= fin_res[WIDTH-1];
                        err_q   <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        a_q <= a_step;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == S_IDLE);
    assign bus.out_valid  = (state == S_DONE);
    assign bus.Alu_result = res_q;
    assign bus.Zero       = zero_q;
    assign bus.Carry      = carry_q;
    assign bus.Overflow   = ovf_q;
    assign bus.Negative   = neg_q;
    assign bus.Err        = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model expectations, monitor pops on each output handshake.
module tb_alu_seq;
    localparam int WIDTH = 16;
    localparam int TMO   = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             c;
        logic             v;
        logic             n;
        logic             e;
        int               acc_cyc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   force_low  = 1'b0;
    bit   ready_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode semantics.
    function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sbv, r, lim, mask;
        int     n;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        lim  = longint'(1) << (WIDTH - 1);
        mask = (longint'(1) << WIDTH) - 1;
        n    = int'(ub % WIDTH);
        e.c = 1'b0; e.v = 1'b0; e.e = 1'b0; e.lat = 0; e.acc_cyc = 0;
        case (op)
            4'h0: begin
                r   = ua + ub;
                e.c = (r > mask);
                e.v = ((sa + sbv) >= lim) || ((sa + sbv) < -lim);
            end
            4'h1: begin
                r   = ua - ub;
                e.c = (ua < ub);
                e.v = ((sa - sbv) >= lim) || ((sa - sbv) < -lim);
            end
            4'h2: r = ua & ub;
            4'h3: r = ua | ub;
            4'h4: r = ua ^ ub;
            4'h5: r = (sa < sbv) ? 1 : 0;
            4'h6: begin r = ua << n; e.lat = n; end
            4'h7: begin r = ua >> n; e.lat = n; end
`ifdef ALU_MUL_EN
            4'h8: begin
                r     = ua * ub;
                e.c   = (r > mask);
                e.lat = WIDTH;
            end
`endif
            default: begin r = 0; e.e = 1'b1; end
        endcase
        r     = r & mask;
        e.res = r[WIDTH-1:0];
        e.z   = (e.res == '0);
        e.n   = e.res[WIDTH-1];
        return e;
    endfunction

    // Called at a negedge; holds the request until the DUT can take it.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int   w;
        exp_t e;
        bus.in_valid    = 1'b1;
        bus.Alu_control = op;
        bus.Alu_inputA  = a;
        bus.Alu_inputB  = b;
        w = 0;
        while (!bus.in_ready && w < TMO) begin
            @(negedge clk);
            w++;
        end
        if (w >= TMO) begin
            chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            e = model(op, a, b);
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_result"},    32'(bus.Alu_result), 32'd0);
        chk({tag, "_flags"},     32'({bus.Zero, bus.Carry, bus.Overflow, bus.Negative, bus.Err}), 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = force_low ? 1'b0 : (ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    // Monitor: latency, stability under backpressure, handshake compare.
    initial begin
        bit               prev_v;
        bit               ready_chk;
        int               first_cyc;
        logic [WIDTH-1:0] held_r;
        logic [4:0]       held_f;
        exp_t             e;
        prev_v = 1'b0; ready_chk = 1'b0; first_cyc = 0; held_r = '0; held_f = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v    = 1'b0;
                ready_chk = 1'b0;
                continue;
            end
            if (ready_chk) begin
                chk("in_ready_after_accept", 32'(bus.in_ready), 32'd1);
                ready_chk = 1'b0;
            end
            if (bus.out_valid) begin
                if (!prev_v) begin
                    first_cyc = cyc;
                    held_r    = bus.Alu_result;
                    held_f    = {bus.Zero, bus.Carry, bus.Overflow, bus.Negative, bus.Err};
                end else begin
                    chk("stable_result", 32'(bus.Alu_result), 32'(held_r));
                    chk("stable_flags", 32'({bus.Zero, bus.Carry, bus.Overflow, bus.Negative, bus.Err}),
                        32'(held_f));
                end
                chk("in_ready_while_valid", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("result",   32'(bus.Alu_result), 32'(e.res));
                        chk("zero",     32'(bus.Zero),       32'(e.z));
                        chk("carry",    32'(bus.Carry),      32'(e.c));
                        chk("overflow", 32'(bus.Overflow),   32'(e.v));
                        chk("negative", 32'(bus.Negative),   32'(e.n));
                        chk("err",      32'(bus.Err),        32'(e.e));
                        chk("latency",  32'(first_cyc - e.acc_cyc), 32'(e.lat));
                    end
                    ready_chk = 1'b1;
                end
            end
            prev_v = bus.out_valid && !bus.out_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w;
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bus.in_valid    = 1'b0;
        bus.Alu_control = '0;
        bus.Alu_inputA  = '0;
        bus.Alu_inputB  = '0;
        #1;
        check_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        issue(4'h0, 16'hAB03, 16'h32FF);
        issue(4'h1, 16'h8000, 16'h0001);
        issue(4'h1, 16'h0004, 16'h0004);
        issue(4'h1, 16'h0003, 16'h0004);
        issue(4'h6, 16'hAB03, 16'h0004);
        issue(4'h7, 16'hAB03, 16'h0000);
        issue(4'h7, 16'h8001, 16'h000F);
        issue(4'h5, 16'hFFFF, 16'h0001);
        issue(4'h9, 16'h1234, 16'h5678);
        issue(4'h8, 16'h0012, 16'h0034);
        issue(4'h8, 16'hFFFF, 16'h0003);

        // Backpressure: result held while a second request waits.
        repeat (WIDTH + 4) @(negedge clk);
        force_low = 1'b1;
        issue(4'h0, 16'h7FFF, 16'h0001);
        fork
            begin
                repeat (2) @(negedge clk);
                force_low = 1'b0;
            end
        join_none
        issue(4'h4, 16'hF0F0, 16'h0FF0);

        // Asynchronous reset in the third BUSY cycle of SHL by 15.
        repeat (6) @(negedge clk);
        issue(4'h6, 16'hAB03, 16'h000F);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_busy_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        issue(4'h0, 16'h1111, 16'h2222);

        ready_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            if ($urandom_range(0, 9) == 0) b = 16'hFFFF;
            issue(op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        w = 0;
        while (sb.size() != 0 && w < TMO) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
